// File: rtl/pe_vector_unit_if.sv
// Command/result bundle between the PE fetch unit (master) and the PE vector unit (slave).
interface pe_vector_unit_if #(
    parameter int DATA_LEN      = 32,
    parameter int PE_ELEMENTS   = 4,
    parameter int PE_OPCODE_LEN = 4
) ();
    logic [PE_OPCODE_LEN-1:0]          pe_opcode;
    logic [PE_ELEMENTS*DATA_LEN-1:0]   data_a;
    logic [PE_ELEMENTS*DATA_LEN-1:0]   data_b;
    logic                              pe_stage_1_valid;
    logic [PE_ELEMENTS*DATA_LEN-1:0]   pe_stage_1_output;
    logic                              pe_stage_2_valid;
    logic [DATA_LEN-1:0]               pe_stage_2_output;
    logic                              store_result;
    logic                              stop;
    logic                              busy;

    modport master (
        output pe_opcode, data_a, data_b,
        input  pe_stage_1_valid, pe_stage_1_output,
        input  pe_stage_2_valid, pe_stage_2_output,
        input  store_result, stop, busy
    );

    modport slave (
        input  pe_opcode, data_a, data_b,
        output pe_stage_1_valid, pe_stage_1_output,
        output pe_stage_2_valid, pe_stage_2_output,
        output store_result, stop, busy
    );
endinterface

// File: rtl/pe_vector_unit.sv
// PE vector unit: lane-wise ADD/SUB/MUL into s1 register, and a two-deep
// pipelined dot product with a forwarding path for back-to-back stores.
module pe_vector_unit #(
    parameter int DATA_LEN      = 32,
    parameter int PE_ELEMENTS   = 4,
    parameter int PE_OPCODE_LEN = 4
) (
    input logic          clk,
    input logic          rstn,
    pe_vector_unit_if.slave pe
);
    localparam int VW = PE_ELEMENTS * DATA_LEN;

    localparam logic [PE_OPCODE_LEN-1:0] OP_ADD  = PE_OPCODE_LEN'(1);
    localparam logic [PE_OPCODE_LEN-1:0] OP_SUB  = PE_OPCODE_LEN'(2);
    localparam logic [PE_OPCODE_LEN-1:0] OP_MUL  = PE_OPCODE_LEN'(3);
    localparam logic [PE_OPCODE_LEN-1:0] OP_DOTP = PE_OPCODE_LEN'(4);
    localparam logic [PE_OPCODE_LEN-1:0] OP_ST1  = PE_OPCODE_LEN'(5);
    localparam logic [PE_OPCODE_LEN-1:0] OP_ST2  = PE_OPCODE_LEN'(6);
    localparam logic [PE_OPCODE_LEN-1:0] OP_STR  = PE_OPCODE_LEN'(7);
    localparam logic [PE_OPCODE_LEN-1:0] OP_STOP = PE_OPCODE_LEN'(8);

    typedef logic [DATA_LEN-1:0] lane_t;

    lane_t a_l [PE_ELEMENTS];
    lane_t b_l [PE_ELEMENTS];

    logic is_add, is_sub, is_mul, is_dotp;
    logic is_st1, is_st2, is_str, is_stop;

    lane_t s1_q   [PE_ELEMENTS];
    lane_t s1_d   [PE_ELEMENTS];
    lane_t prod_q [PE_ELEMENTS];
    lane_t prod_d [PE_ELEMENTS];
    lane_t sum_q, sum_d;
    lane_t dot_sum;
    logic  m_vld_q, m_vld_d;

    logic [VW-1:0] s1_flat;
    logic [VW-1:0] s1_out_q, s1_out_d;
    lane_t         s2_out_q, s2_out_d;
    logic          s1_vld_q, s1_vld_d;
    logic          s2_vld_q, s2_vld_d;
    logic          str_q, str_d;
    logic          stop_q, stop_d;

    always_comb begin
        for (int i = 0; i < PE_ELEMENTS; i++) begin
            a_l[i] = pe.data_a[i*DATA_LEN +: DATA_LEN];
            b_l[i] = pe.data_b[i*DATA_LEN +: DATA_LEN];
        end
    end

    always_comb begin
        is_add  = 1'b0;
        is_sub  = 1'b0;
        is_mul  = 1'b0;
        is_dotp = 1'b0;
        is_st1  = 1'b0;
        is_st2  = 1'b0;
        is_str  = 1'b0;
        is_stop = 1'b0;
        unique case (pe.pe_opcode)
            OP_ADD:  is_add  = 1'b1;
            OP_SUB:  is_sub  = 1'b1;
            OP_MUL:  is_mul  = 1'b1;
            OP_DOTP: is_dotp = 1'b1;
            OP_ST1:  is_st1  = 1'b1;
            OP_ST2:  is_st2  = 1'b1;
            OP_STR:  is_str  = 1'b1;
            OP_STOP: is_stop = 1'b1;
            default: ;
        endcase
    end

    // Wrapping adder over the product register feeds both sum_q and the forward path.
    always_comb begin
        dot_sum = '0;
        for (int i = 0; i < PE_ELEMENTS; i++) begin
            dot_sum = dot_sum + prod_q[i];
        end
    end

    always_comb begin
        s1_flat = '0;
        for (int i = 0; i < PE_ELEMENTS; i++) begin
            s1_flat[i*DATA_LEN +: DATA_LEN] = s1_q[i];
        end
    end

    always_comb begin
        for (int i = 0; i < PE_ELEMENTS; i++) begin
            s1_d[i]   = s1_q[i];
            prod_d[i] = prod_q[i];
            if (is_add) s1_d[i] = a_l[i] + b_l[i];
            if (is_sub) s1_d[i] = a_l[i] - b_l[i];
            if (is_mul) s1_d[i] = a_l[i] * b_l[i];
            if (is_dotp) prod_d[i] = a_l[i] * b_l[i];
        end
        m_vld_d  = is_dotp;
        sum_d    = m_vld_q ? dot_sum : sum_q;
        s1_out_d = is_st1 ? s1_flat : s1_out_q;
        s2_out_d = s2_out_q;
        if (is_st2) s2_out_d = m_vld_q ? dot_sum : sum_q;
        s1_vld_d = is_st1;
        s2_vld_d = is_st2;
        str_d    = is_str;
        stop_d   = is_stop;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < PE_ELEMENTS; i++) begin
                s1_q[i]   <= '0;
                prod_q[i] <= '0;
            end
            sum_q    <= '0;
            m_vld_q  <= 1'b0;
            s1_out_q <= '0;
            s2_out_q <= '0;
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            str_q    <= 1'b0;
            stop_q   <= 1'b0;
        end else begin
            for (int i = 0; i < PE_ELEMENTS; i++) begin
                s1_q[i]   <= s1_d[i];
                prod_q[i] <= prod_d[i];
            end
            sum_q    <= sum_d;
            m_vld_q  <= m_vld_d;
            s1_out_q <= s1_out_d;
            s2_out_q <= s2_out_d;
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            str_q    <= str_d;
            stop_q   <= stop_d;
        end
    end

    assign pe.pe_stage_1_valid  = s1_vld_q;
    assign pe.pe_stage_1_output = s1_out_q;
    assign pe.pe_stage_2_valid  = s2_vld_q;
    assign pe.pe_stage_2_output = s2_out_q;
    assign pe.store_result      = str_q;
    assign pe.stop              = stop_q;
    assign pe.busy              = m_vld_q;
endmodule

// File: tb/tb_pe_vector_unit.sv
// Directed and randomized checks of pe_vector_unit against an arithmetic
// model of lane ops and "latest dot product" semantics.
module tb_pe_vector_unit;
    localparam int DL = 32;
    localparam int NE = 4;
    localparam int OL = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    pe_vector_unit_if #(.DATA_LEN(DL), .PE_ELEMENTS(NE), .PE_OPCODE_LEN(OL)) bus ();

    pe_vector_unit #(.DATA_LEN(DL), .PE_ELEMENTS(NE), .PE_OPCODE_LEN(OL)) dut (
        .clk  (clk),
        .rstn (rstn),
        .pe   (bus)
    );

    always #5 clk = ~clk;

    logic [DL-1:0]    m_s1 [NE];
    logic [DL-1:0]    m_dot;
    logic [NE*DL-1:0] e_s1_out;
    logic [DL-1:0]    e_s2_out;

    function automatic logic [NE*DL-1:0] v4(input int x0, x1, x2, x3);
        logic [NE*DL-1:0] v;
        v = {32'(x3), 32'(x2), 32'(x1), 32'(x0)};
        return v;
    endfunction

    function automatic logic [NE*DL-1:0] vrand();
        logic [NE*DL-1:0] v;
        for (int i = 0; i < NE; i++) begin
            if ($urandom_range(0, 3) == 0) v[i*DL +: DL] = 32'($urandom_range(0, 9));
            else v[i*DL +: DL] = $urandom;
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [NE*DL-1:0] obs, input logic [NE*DL-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NE; i++) m_s1[i] = '0;
        m_dot    = '0;
        e_s1_out = '0;
        e_s2_out = '0;
    endtask

    task automatic check_all(input int op);
        chk("s1_valid", 128'(bus.pe_stage_1_valid), 128'(op == 5));
        chk("s1_out",   bus.pe_stage_1_output, e_s1_out);
        chk("s2_valid", 128'(bus.pe_stage_2_valid), 128'(op == 6));
        chk("s2_out",   128'(bus.pe_stage_2_output), 128'(e_s2_out));
        chk("store",    128'(bus.store_result), 128'(op == 7));
        chk("stop",     128'(bus.stop), 128'(op == 8));
        chk("busy",     128'(bus.busy), 128'(op == 4));
    endtask

    task automatic cyc(input int op, input logic [NE*DL-1:0] a, input logic [NE*DL-1:0] b);
        logic [DL-1:0] x, y, acc;
        @(negedge clk);
        bus.pe_opcode = OL'(op);
        bus.data_a    = a;
        bus.data_b    = b;
        acc = '0;
        for (int i = 0; i < NE; i++) begin
            x = a[i*DL +: DL];
            y = b[i*DL +: DL];
            if (op == 1) m_s1[i] = x + y;
            if (op == 2) m_s1[i] = x - y;
            if (op == 3) m_s1[i] = DL'(64'(x) * 64'(y));
            acc = acc + DL'(64'(x) * 64'(y));
        end
        if (op == 5) for (int i = 0; i < NE; i++) e_s1_out[i*DL +: DL] = m_s1[i];
        if (op == 6) e_s2_out = m_dot;
        if (op == 4) m_dot = acc;
        @(posedge clk);
        #1;
        check_all(op);
    endtask

    initial begin
        logic [NE*DL-1:0] z;
        z = '0;
        bus.pe_opcode = '0;
        bus.data_a = '0;
        bus.data_b = '0;
        model_reset();
        #1;
        check_all(0);
        #12 rstn = 1'b1;

        // Lane-wise add then store
        cyc(1, v4(1, 2, 3, 4), v4(10, 20, 30, 40));
        cyc(5, z, z);
        chk("t1_vec", bus.pe_stage_1_output, v4(11, 22, 33, 44));
        cyc(0, z, z);

        // Wrap cases: SUB underflow, MUL overflow
        cyc(2, v4(0, 5, 7, 0), v4(1, 2, 9, 0));
        cyc(5, z, z);
        chk("t2_sub", 128'(bus.pe_stage_1_output[31:0]), 128'(32'hFFFF_FFFF));
        cyc(3, v4(32'h10000, 3, 32'h8000_0000, -1), v4(32'h10000, 4, 2, -1));
        cyc(5, z, z);
        chk("t2_mul", 128'(bus.pe_stage_1_output[31:0]), 128'(0));

        // Dot product via forward path and via sum register
        cyc(4, v4(1, 2, 3, 4), v4(5, 6, 7, 8));
        cyc(6, z, z);
        chk("t3_fwd", 128'(bus.pe_stage_2_output), 128'(70));
        cyc(4, v4(1, 2, 3, 4), v4(5, 6, 7, 8));
        repeat (3) cyc(0, z, z);
        cyc(6, z, z);
        chk("t3_sum", 128'(bus.pe_stage_2_output), 128'(70));

        // Back-to-back DOTPs then repeated stores
        cyc(4, v4(1, 2, 3, 4), v4(5, 6, 7, 8));
        cyc(4, v4(1, 1, 1, 1), v4(1, 1, 1, 1));
        repeat (4) cyc(6, z, z);
        chk("t4_last", 128'(bus.pe_stage_2_output), 128'(4));

        // Control pulses and an unused opcode
        cyc(7, z, z);
        cyc(8, z, z);
        cyc(12, z, z);
        cyc(0, z, z);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            int op;
            op = (n % 5 == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 6));
            cyc(op, vrand(), vrand());
        end

        // Asynchronous reset with a DOTP in flight
        cyc(4, v4(2, 3, 4, 5), v4(6, 7, 8, 9));
        cyc(1, v4(1, 1, 1, 1), v4(1, 1, 1, 1));
        cyc(4, v4(2, 3, 4, 5), v4(6, 7, 8, 9));
        #2 rstn = 1'b0;
        #1;
        model_reset();
        check_all(0);
        @(negedge clk);
        bus.pe_opcode = '0;
        rstn = 1'b1;
        cyc(6, z, z);
        chk("t6_zero", 128'(bus.pe_stage_2_output), 128'(0));
        cyc(5, z, z);
        cyc(0, z, z);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
